// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal arithmetic datapath.
//   DIGIT_W : width of one packed-BCD digit
//   BCD_MAX : largest legal BCD digit value
//   state_t : control states of the digit-serial subtractor
//   is_bcd  : 1 when a digit lies in 0..9
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract cell: d = a_d - b_d - bin, with
// borrow-and-add-ten correction.
//   a_d, b_d : minuend / subtrahend digit
//   bin      : borrow in
//   d        : result digit (truncated to 4 bits for illegal inputs)
//   bout     : borrow out
//   bad      : either input digit exceeds 9
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout,
  output logic               bad
);

  localparam int unsigned T_W = DIGIT_W + 1;
  localparam logic [DIGIT_W-1:0] TEN = DIGIT_W'(10);

  logic [T_W-1:0] t;

  // t spans -16..15, so its MSB is the sign of the 5-bit result
  always_comb begin
    t    = {1'b0, a_d} - {1'b0, b_d} - T_W'(bin);
    bout = t[T_W-1];
    d    = bout ? (t[DIGIT_W-1:0] + TEN) : t[DIGIT_W-1:0];
    bad  = !is_bcd(a_d) || !is_bcd(b_d);
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - b_in, LS digit first,
// one digit per clock, valid/ready on both sides.
// Optional macro BCD_SUB_SIGNMAG_EN: negative results are re-negated in a NEG
// pass so diff holds the magnitude and neg flags the sign.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, b_in)
//   out_valid / out_ready: result handshake (diff, b_out, err [, neg])
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      b_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] diff,
  output logic                      b_out,
  output logic                      err
`ifdef BCD_SUB_SIGNMAG_EN
  ,
  output logic                      neg
`endif
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t state, state_nxt;

  logic [W-1:0]       a_q, b_q;
  logic               br_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DIGIT_W-1:0] cell_a, cell_b, cell_d;
  logic               cell_bin, cell_bout, cell_bad;
  logic               accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == IDX_LAST);

  // Shared cell: operands in CALC, 0 - diff in NEG
  always_comb begin
    cell_a   = a_q[DIGIT_W-1:0];
    cell_b   = b_q[DIGIT_W-1:0];
    cell_bin = br_q;
`ifdef BCD_SUB_SIGNMAG_EN
    if (state == NEG) begin
      cell_a = '0;
      cell_b = diff[DIGIT_W-1:0];
    end
`endif
  end

  bcd_digit_sub u_cell (
    .a_d  (cell_a),
    .b_d  (cell_b),
    .bin  (cell_bin),
    .d    (cell_d),
    .bout (cell_bout),
    .bad  (cell_bad)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (last) begin
`ifdef BCD_SUB_SIGNMAG_EN
          state_nxt = cell_bout ? NEG : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGNMAG_EN
      NEG:  if (last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      br_q      <= 1'b0;
      idx_q     <= '0;
      diff      <= '0;
      b_out     <= 1'b0;
      err       <= 1'b0;
`ifdef BCD_SUB_SIGNMAG_EN
      neg       <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= b_in;
            idx_q <= '0;
            err   <= 1'b0;
            b_out <= 1'b0;
`ifdef BCD_SUB_SIGNMAG_EN
            neg   <= 1'b0;
`endif
          end
        end
        CALC: begin
          a_q   <= a_q >> DIGIT_W;
          b_q   <= b_q >> DIGIT_W;
          // new digit enters at the top; after DIGITS shifts digit 0 is at [3:0]
          diff  <= (diff >> DIGIT_W) | (W'(cell_d) << (W - DIGIT_W));
          err   <= err | cell_bad;
          br_q  <= cell_bout;
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) begin
            b_out <= cell_bout;
            br_q  <= 1'b0;  // negation pass starts with no borrow
          end
        end
`ifdef BCD_SUB_SIGNMAG_EN
        NEG: begin
          diff  <= (diff >> DIGIT_W) | (W'(cell_d) << (W - DIGIT_W));
          br_q  <= cell_bout;
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) neg <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=4).
// Honours BCD_SUB_SIGNMAG_EN when defined for the build.
module tb_bcd_serial_subtractor;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
`ifdef BCD_SUB_SIGNMAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         err;
`ifdef BCD_SUB_SIGNMAG_EN
  logic         neg;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .err       (err)
`ifdef BCD_SUB_SIGNMAG_EN
    ,
    .neg       (neg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge and let the next posedge accept them
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input string tag);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; b_in = bi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen
  task automatic wait_out(input int exp_lat, input string tag);
    int cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      if (cycles == 0) begin
        @(posedge clk);
        #1;
        if (out_valid) cycles = i;
      end
    end
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
  endtask

  task automatic check_result(input logic [W-1:0] ed, input logic eb, input logic ee,
                              input logic en, input string tag);
    check({tag, " diff"},  32'(diff),  32'(ed));
    check({tag, " b_out"}, 32'(b_out), 32'(eb));
    check({tag, " err"},   32'(err),   32'(ee));
`ifdef BCD_SUB_SIGNMAG_EN
    check({tag, " neg"},   32'(neg),   32'(en));
`else
    if (en) check({tag, " neg in default build"}, 32'd1, 32'd0);
`endif
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset diff",      32'(diff),      32'd0);
    check("reset b_out",     32'(b_out),     32'd0);
    check("reset err",       32'(err),       32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 0042 - 0017 = 0025
    start_op(16'h0042, 16'h0017, 1'b0, "t1");
    wait_out(4, "t1");
    check_result(16'h0025, 1'b0, 1'b0, 1'b0, "t1");
    consume("t1");

    // 0017 - 0042: ten's complement 9975, or magnitude 0025 with neg
    start_op(16'h0017, 16'h0042, 1'b0, "t2");
    wait_out(SM ? 8 : 4, "t2");
    check_result(SM ? 16'h0025 : 16'h9975, 1'b1, 1'b0, SM, "t2");
    consume("t2");

    // 1000 - 0001 - 1 = 0998
    start_op(16'h1000, 16'h0001, 1'b1, "t3");
    wait_out(4, "t3");
    check_result(16'h0998, 1'b0, 1'b0, 1'b0, "t3");
    consume("t3");

    // 0000 - 0000 - 1 wraps to 9999 (magnitude 0001)
    start_op(16'h0000, 16'h0000, 1'b1, "t4");
    wait_out(SM ? 8 : 4, "t4");
    check_result(SM ? 16'h0001 : 16'h9999, 1'b1, 1'b0, SM, "t4");
    consume("t4");

    // Illegal digit A: 00A0 - 0001 -> digits 9, A-1=9 -> 0099, err
    start_op(16'h00A0, 16'h0001, 1'b0, "t5");
    wait_out(4, "t5");
    check_result(16'h0099, 1'b0, 1'b1, 1'b0, "t5");
    consume("t5");

    // err clears on the next accept
    start_op(16'h0005, 16'h0003, 1'b0, "t6");
    wait_out(4, "t6");
    check_result(16'h0002, 1'b0, 1'b0, 1'b0, "t6");
    consume("t6");

    // Backpressure: result held, new request waits for consumption
    start_op(16'h0042, 16'h0017, 1'b0, "bp");
    wait_out(4, "bp");
    a = 16'h0005; b = 16'h0003; b_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold in_ready",  32'(in_ready),  32'd0);
      check("bp hold diff",      32'(diff),      32'h0025);
      check("bp hold b_out",     32'(b_out),     32'd0);
      check("bp hold err",       32'(err),       32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp consumed out_valid", 32'(out_valid), 32'd0);
    check("bp consumed in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp second accepted", 32'(in_ready), 32'd0);
    wait_out(4, "bp2");
    check_result(16'h0002, 1'b0, 1'b0, 1'b0, "bp2");
    consume("bp2");

    // Reset mid-CALC at idx=2
    start_op(16'h0042, 16'h0017, 1'b0, "rst");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst diff",      32'(diff),      32'd0);
    check("rst b_out",     32'(b_out),     32'd0);
    check("rst err",       32'(err),       32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst no out_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post-rst no out_valid", 32'(out_valid), 32'd0);
    end

    // Fresh operation after abort
    start_op(16'h1000, 16'h0001, 1'b1, "fresh");
    wait_out(4, "fresh");
    check_result(16'h0998, 1'b0, 1'b0, 1'b0, "fresh");
    consume("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
